fifo_access_arbiter: RTL and testbench

- Sequences access to the 16-deep FIFO for two producers (A, B) and one consumer.
- Drives the FIFO's active-low Read/Write strobes and its ClearOV input, and feeds its DataIn.
- Arbitrates the two writers round-robin and alternates reads with writes when both are pending.
- Applies a configurable full-FIFO policy and clears overflow automatically.

---
 rtl/fifo_access_arbiter.sv | 139 +++++++++++++
 tb/tb_fifo_access_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_access_arbiter.sv
// Access sequencer for a 16-deep FIFO shared by two producers and one
// consumer. Writers are arbitrated round-robin, reads and writes alternate
// when both are pending, overflow is cleared automatically, and a full FIFO
// either stalls or discards writes depending on DROP_ON_FULL.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | flags sampled, next operation chosen (or a write discarded)
// WR      | WriteN low for one cycle, granted producer acked
// RD      | ReadN low for one cycle; FIFO updates DataOut on the negedge
// RD_DATA | FIFO DataOut captured into ReadData, ReadValid pulsed
// CLR     | ClearOV high for one cycle, no strobes
module fifo_access_arbiter #(
  parameter int FIFOWIDTH    = 9,
  parameter bit DROP_ON_FULL = 1'b0,
  parameter int DROPW        = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 ReqA,
  input  logic [FIFOWIDTH-1:0] DataA,
  input  logic                 ReqB,
  input  logic [FIFOWIDTH-1:0] DataB,
  input  logic                 ReadReq,
  input  logic                 Full,
  input  logic                 EMPTY,
  input  logic                 OV,
  input  logic [FIFOWIDTH-1:0] FifoDataOut,
  output logic                 WriteN,
  output logic                 ReadN,
  output logic                 ClearOV,
  output logic [FIFOWIDTH-1:0] FifoDataIn,
  output logic                 AckA,
  output logic                 AckB,
  output logic                 ReadValid,
  output logic [FIFOWIDTH-1:0] ReadData,
  output logic [DROPW-1:0]     DropCount
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_DATA = 3'd3,
    CLR     = 3'd4
  } state_t;

  state_t state;
  logic   rr_ptr;     // 0 = A favoured, 1 = B favoured
  logic   last_read;  // 1 when the most recent served operation was a read

  logic req_any;
  logic rd_ok;
  logic wr_ok;
  logic sel_b;
  logic serve_rd;
  logic do_drop;

  // Decision terms evaluated from the flags as they stand in IDLE.
  assign req_any  = ReqA | ReqB;
  assign rd_ok    = ReadReq & ~EMPTY;
  assign wr_ok    = req_any & ~Full;
  // Favoured side wins if it is requesting, otherwise the other side.
  assign sel_b    = rr_ptr ? ReqB : ~ReqA;
  // When both kinds are eligible, serve the one that did not go last.
  assign serve_rd = rd_ok & ~(wr_ok & last_read);
  assign do_drop  = DROP_ON_FULL & req_any & Full;

  // Sequencer: state, round-robin pointer and all registered outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      last_read  <= 1'b0;
      WriteN     <= 1'b1;
      ReadN      <= 1'b1;
      ClearOV    <= 1'b0;
      AckA       <= 1'b0;
      AckB       <= 1'b0;
      ReadValid  <= 1'b0;
      ReadData   <= '0;
      FifoDataIn <= '0;
      DropCount  <= '0;
    end else begin
      WriteN    <= 1'b1;
      ReadN     <= 1'b1;
      ClearOV   <= 1'b0;
      AckA      <= 1'b0;
      AckB      <= 1'b0;
      ReadValid <= 1'b0;
      case (state)
        IDLE: begin
          if (OV) begin
            state   <= CLR;
            ClearOV <= 1'b1;
          end else if (serve_rd) begin
            state     <= RD;
            ReadN     <= 1'b0;
            last_read <= 1'b1;
          end else if (wr_ok) begin
            state      <= WR;
            WriteN     <= 1'b0;
            FifoDataIn <= sel_b ? DataB : DataA;
            AckA       <= ~sel_b;
            AckB       <= sel_b;
            rr_ptr     <= ~sel_b;
            last_read  <= 1'b0;
          end else if (do_drop) begin
            AckA   <= ~sel_b;
            AckB   <= sel_b;
            rr_ptr <= ~rr_ptr;
            if (DropCount != '1) begin
              DropCount <= DropCount + DROPW'(1);
            end
          end
        end
        WR: begin
          state <= IDLE;
        end
        RD: begin
          // DataOut was refreshed by the FIFO on this cycle's negedge.
          state     <= RD_DATA;
          ReadValid <= 1'b1;
          ReadData  <= FifoDataOut;
        end
        RD_DATA: begin
          state <= IDLE;
        end
        CLR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Bench for fifo_access_arbiter: instance 0 stalls on Full, instance 1
// discards on Full. A plan-queue model predicts every output each cycle;
// directed phases add literal expectations.
module tb_fifo_access_arbiter;
  localparam int W = 9;

  typedef struct packed {
    logic wn;
    logic rn;
    logic clr;
    logic aa;
    logic ab;
    logic rv;
  } ent_t;
  localparam ent_t IDLE_E = '{wn: 1'b1, rn: 1'b1, clr: 1'b0, aa: 1'b0, ab: 1'b0, rv: 1'b0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // knobs written only by the main sequence
  int   tgt_a    [2] = '{0, 0};
  int   tgt_b    [2] = '{0, 0};
  int   rd_tgt   [2] = '{0, 0};
  int   ov_raise [2] = '{0, 0};
  logic full     [2] = '{1'b0, 1'b0};
  logic empty    [2] = '{1'b1, 1'b1};

  // environment state written only by the producer/FIFO process
  int         acked_a [2] = '{0, 0};
  int         acked_b [2] = '{0, 0};
  int         rd_done [2] = '{0, 0};
  int         clr_cnt [2] = '{0, 0};
  int         nreads  [2] = '{0, 0};
  int         wn_low  [2] = '{0, 0};
  logic [W-1:0] fdout [2] = '{9'h000, 9'h000};

  logic         req_a [2];
  logic         req_b [2];
  logic         read_req [2];
  logic         ov [2];
  logic [W-1:0] data_a [2];
  logic [W-1:0] data_b [2];
  logic         wn [2];
  logic         rn [2];
  logic         clr [2];
  logic         aa [2];
  logic         ab [2];
  logic         rv [2];
  logic [W-1:0] fdin [2];
  logic [W-1:0] rdata [2];
  logic [7:0]   dcnt [2];

  function automatic logic [W-1:0] da(input int g, input int n);
    return W'(17 + 64 * g + 7 * n);
  endfunction

  function automatic logic [W-1:0] db(input int g, input int n);
    return W'(200 + 32 * g + 11 * n);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // sel: 0 any ack, 1 WriteN low, 2 ReadValid, 3 ClearOV
  task automatic wait_sig(input int g, input int sel, input int budget, input string nm);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < budget && !hit; c++) begin
      @(negedge clk);
      #1;
      case (sel)
        0: hit = aa[g] | ab[g];
        1: hit = !wn[g];
        2: hit = rv[g];
        default: hit = clr[g];
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s timeout actual=none required=event", nm);
    end
  endtask

  // producers, consumer and FIFO side reacting to the arbiter's outputs
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (aa[i]) acked_a[i]++;
      if (ab[i]) acked_b[i]++;
      if (rv[i]) rd_done[i]++;
      if (clr[i]) clr_cnt[i]++;
      if (!wn[i]) wn_low[i]++;
      if (!rn[i]) begin
        fdout[i] = W'(9'h1A5 + 3 * nreads[i]);
        nreads[i]++;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam bit DROP = (g == 1);

    assign req_a[g]    = acked_a[g] < tgt_a[g];
    assign req_b[g]    = acked_b[g] < tgt_b[g];
    assign read_req[g] = rd_done[g] < rd_tgt[g];
    assign ov[g]       = clr_cnt[g] < ov_raise[g];
    assign data_a[g]   = da(g, acked_a[g]);
    assign data_b[g]   = db(g, acked_b[g]);

    fifo_access_arbiter #(.FIFOWIDTH(W), .DROP_ON_FULL(DROP), .DROPW(8)) dut (
      .Clock      (clk),
      .Reset      (rst_n),
      .ReqA       (req_a[g]),
      .DataA      (data_a[g]),
      .ReqB       (req_b[g]),
      .DataB      (data_b[g]),
      .ReadReq    (read_req[g]),
      .Full       (full[g]),
      .EMPTY      (empty[g]),
      .OV         (ov[g]),
      .FifoDataOut(fdout[g]),
      .WriteN     (wn[g]),
      .ReadN      (rn[g]),
      .ClearOV    (clr[g]),
      .FifoDataIn (fdin[g]),
      .AckA       (aa[g]),
      .AckB       (ab[g]),
      .ReadValid  (rv[g]),
      .ReadData   (rdata[g]),
      .DropCount  (dcnt[g])
    );

    // model: each served operation expands into a list of output cycles
    ent_t         cur     = IDLE_E;
    ent_t         plan[$];
    bit           rr_b    = 1'b0;
    bit           last_rd = 1'b0;
    logic [W-1:0] e_fdin  = '0;
    logic [W-1:0] e_rdata = '0;
    int           e_drop  = 0;

    always @(posedge clk or negedge rst_n) begin : model
      bit   any, can_rd, can_wr, pick_b;
      ent_t t;
      if (!rst_n) begin
        plan.delete();
        cur = IDLE_E; rr_b = 1'b0; last_rd = 1'b0;
        e_fdin = '0; e_rdata = '0; e_drop = 0;
      end else if (plan.size() > 0) begin
        cur = plan.pop_front();
        if (cur.rv) e_rdata = fdout[g];
      end else begin
        any    = req_a[g] || req_b[g];
        can_rd = read_req[g] && !empty[g];
        can_wr = any && !full[g];
        pick_b = (rr_b && req_b[g]) || !req_a[g];
        cur    = IDLE_E;
        if (ov[g]) begin
          cur.clr = 1'b1;
          plan.push_back(IDLE_E);
        end else if (can_rd && !(can_wr && last_rd)) begin
          cur.rn  = 1'b0;
          last_rd = 1'b1;
          t = IDLE_E; t.rv = 1'b1;
          plan.push_back(t);
          plan.push_back(IDLE_E);
        end else if (can_wr) begin
          cur.wn  = 1'b0;
          cur.aa  = !pick_b;
          cur.ab  = pick_b;
          e_fdin  = pick_b ? data_b[g] : data_a[g];
          rr_b    = !pick_b;
          last_rd = 1'b0;
          plan.push_back(IDLE_E);
        end else if (DROP && any && full[g]) begin
          cur.aa = !pick_b;
          cur.ab = pick_b;
          if (e_drop < 255) e_drop++;
          rr_b = !rr_b;
        end
      end
    end

    always @(negedge clk) begin : compare
      chk($sformatf("i%0d_WriteN", g), wn[g], cur.wn);
      chk($sformatf("i%0d_ReadN", g), rn[g], cur.rn);
      chk($sformatf("i%0d_ClearOV", g), clr[g], cur.clr);
      chk($sformatf("i%0d_AckA", g), aa[g], cur.aa);
      chk($sformatf("i%0d_AckB", g), ab[g], cur.ab);
      chk($sformatf("i%0d_ReadValid", g), rv[g], cur.rv);
      chk($sformatf("i%0d_ReadData", g), rdata[g], e_rdata);
      chk($sformatf("i%0d_FifoDataIn", g), fdin[g], e_fdin);
      chk($sformatf("i%0d_DropCount", g), dcnt[g], e_drop);
      chk($sformatf("i%0d_strobe_overlap", g), (!wn[g] && !rn[g]) ? 1 : 0, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, b0, c0, r0, w0, d, n;
    int ops [4];
    bit rv_seen;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_WriteN", wn[0], 1);
    chk("reset_ReadN", rn[0], 1);
    chk("reset_DropCount", dcnt[1], 0);
    chk("reset_ReadData", rdata[0], 0);
    chk("reset_FifoDataIn", fdin[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    // fairness: both producers held, FIFO empty and never full
    tgt_a[0] = 1000000;
    tgt_b[0] = 1000000;
    for (int k = 0; k < 8; k++) begin
      wait_sig(0, 0, 6, "fair_ack");
      chk("fair_grant_a", aa[0], (k % 2 == 0) ? 1 : 0);
      chk("fair_data", fdin[0], (k % 2 == 0) ? da(0, acked_a[0] - 1) : db(0, acked_b[0] - 1));
    end

    // reset while the write strobe is active
    wait_sig(0, 1, 6, "midwr_wait");
    #1;
    rst_n = 1'b0;
    #1;
    chk("midwr_WriteN", wn[0], 1);
    chk("midwr_AckA", aa[0], 0);
    chk("midwr_AckB", ab[0], 0);
    chk("midwr_DropCount", dcnt[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sig(0, 0, 6, "postrst_ack");
    chk("postrst_first_grant_a", aa[0], 1);
    tgt_a[0] = acked_a[0];
    tgt_b[0] = acked_b[0];
    repeat (4) @(negedge clk);
    #1;

    // read/write alternation
    empty[0]  = 1'b0;
    rd_tgt[0] = 1000000;
    tgt_a[0]  = 1000000;
    n = 0;
    rv_seen = 1'b0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      #1;
      if (!rn[0] && n < 4) begin ops[n] = 1; n++; end
      if (!wn[0] && n < 4) begin ops[n] = 2; n++; end
      if (rv[0] && !rv_seen) begin
        rv_seen = 1'b1;
        chk("alt_first_ReadData", rdata[0], 9'h1A5);
      end
    end
    chk("alt_strobe_count", n, 4);
    chk("alt_rv_seen", rv_seen, 1);
    for (int k = 0; k < 4; k++) chk("alt_op_order", ops[k], (k % 2 == 0) ? 1 : 2);
    tgt_a[0]  = acked_a[0];
    rd_tgt[0] = rd_done[0];
    empty[0]  = 1'b1;
    repeat (6) @(negedge clk);
    #1;

    // Full with stalling policy
    full[0]  = 1'b1;
    tgt_a[0] = acked_a[0] + 1;
    a0 = acked_a[0];
    w0 = wn_low[0];
    repeat (20) @(negedge clk);
    #1;
    chk("full_hold_no_ack", acked_a[0], a0);
    chk("full_hold_no_write", wn_low[0], w0);
    full[0] = 1'b0;
    @(negedge clk);
    #1;
    chk("full_release_WriteN", wn[0], 0);
    chk("full_release_AckA", aa[0], 1);
    repeat (4) @(negedge clk);
    #1;

    // overflow with a write and a read pending
    c0 = clr_cnt[0];
    b0 = acked_b[0];
    r0 = rd_done[0];
    ov_raise[0] = clr_cnt[0] + 1;
    tgt_b[0]    = acked_b[0] + 1;
    rd_tgt[0]   = rd_done[0] + 1;
    empty[0]    = 1'b0;
    @(negedge clk);
    #1;
    chk("ov_ClearOV_first", clr[0], 1);
    chk("ov_no_write_strobe", wn[0], 1);
    chk("ov_no_read_strobe", rn[0], 1);
    for (int c = 0; c < 20 && !(acked_b[0] > b0 && rd_done[0] > r0); c++) begin
      @(negedge clk);
      #1;
    end
    chk("ov_write_served", acked_b[0] - b0, 1);
    chk("ov_read_served", rd_done[0] - r0, 1);
    chk("ov_clear_one_cycle", clr_cnt[0] - c0, 1);
    empty[0] = 1'b1;
    repeat (4) @(negedge clk);
    #1;

    // Full with discard policy: 300 single-word requests
    full[1]  = 1'b1;
    a0 = acked_a[1];
    w0 = wn_low[1];
    tgt_a[1] = acked_a[1] + 300;
    for (int c = 0; c < 400 && (acked_a[1] - a0) < 300; c++) begin
      @(negedge clk);
      #1;
      if (aa[1]) begin
        d = acked_a[1] - a0;
        if (d == 100) chk("drop_count_100", dcnt[1], 100);
        if (d == 255) chk("drop_count_255", dcnt[1], 8'hFF);
      end
    end
    repeat (3) @(negedge clk);
    #1;
    chk("drop_acks", acked_a[1] - a0, 300);
    chk("drop_saturated", dcnt[1], 8'hFF);
    chk("drop_no_write", wn_low[1], w0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
